serial_pattern_tx: RTL and testbench

//   Serial bit-stream transmitter: captures a parallel word on a start request and

---
 rtl/serial_pattern_tx_if.sv | 21 ++
 rtl/serial_pattern_tx.sv | 103 ++++++++++
 tb/tb_serial_pattern_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-output bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, data_in,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-to-serial frame transmitter with optional even parity
module serial_pattern_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit EN_PARITY = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_pattern_tx_if.slave  bus
);
    localparam int FRAME_LEN = WIDTH + (EN_PARITY ? 1 : 0);
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cur_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_SHIFT;
                    shift_d = bus.data_in;
                    par_d   = ^bus.data_in;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                cnt_d   = cnt_q + CW'(1);
                shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                shift_d = '0;
                cnt_d   = '0;
                par_d   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a register, not a gate.
    always_comb begin
        cur_bit = 1'b0;
        if (int'(cnt_d) < WIDTH) begin
            cur_bit = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end else begin
            cur_bit = par_d;
        end
        dvalid_d = (state_d == S_SHIFT);
        busy_d   = (state_d == S_SHIFT);
        done_d   = (state_d == S_DONE);
        dout_d   = (state_d == S_SHIFT) ? cur_bit : 1'b0;
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;

    always #5 clk = ~clk;

    serial_pattern_tx_if #(.WIDTH(8)) ifa ();
    serial_pattern_tx_if #(.WIDTH(8)) ifb ();
    serial_pattern_tx_if #(.WIDTH(8)) ifc ();

    assign ifa.start = start;  assign ifa.data_in = data_in;
    assign ifb.start = start;  assign ifb.data_in = data_in;
    assign ifc.start = start;  assign ifc.data_in = data_in;

    // dut_a: MSB first; dut_b: LSB first; dut_c: LSB first with parity
    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .EN_PARITY(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .EN_PARITY(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .EN_PARITY(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    bit         have  [3];
    int         acc_k [3];
    logic [7:0] cap   [3];
    logic [3:0] exp_o [3];

    function automatic int len_of(input int i);
        return (i == 2) ? 9 : 8;
    endfunction

    function automatic logic frame_bit(input int i, input logic [7:0] d, input int j);
        if (j >= 8) return ^d;
        if (i == 0) return d[7-j];
        return d[j];
    endfunction

    function automatic logic [3:0] get_obs(input int i);
        case (i)
            0:       return {ifa.dout, ifa.dvalid, ifa.busy, ifa.done};
            1:       return {ifb.dout, ifb.dvalid, ifb.busy, ifb.done};
            default: return {ifc.dout, ifc.dvalid, ifc.busy, ifc.done};
        endcase
    endfunction

    // Expected outputs follow from the accept edge k alone: bits for k..k+L-1, done at k+L.
    task automatic tick(input logic s, input logic [7:0] d);
        int rel;
        start   = s;
        data_in = d;
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            if (rst) have[i] = 1'b0;
            else if (s && (!have[i] || (edge_n - acc_k[i]) > len_of(i))) begin
                have[i]  = 1'b1;
                acc_k[i] = edge_n;
                cap[i]   = d;
            end
            rel = edge_n - acc_k[i];
            if (have[i] && rel < len_of(i))       exp_o[i] = {frame_bit(i, cap[i], rel), 3'b110};
            else if (have[i] && rel == len_of(i)) exp_o[i] = 4'b0001;
            else                                  exp_o[i] = 4'b0000;
        end
        @(negedge clk);
    endtask

    task automatic drop_model();
        for (int i = 0; i < 3; i++) begin
            have[i]  = 1'b0;
            exp_o[i] = 4'b0000;
        end
    endtask

    task automatic test_reset();
        int hold;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (get_obs(i) !== 4'b0000) $display("FAIL reset_hold dut%0d obs=%b exp=0000", i, get_obs(i));
            else n_pass++;
        end
        rst = 1'b0;
        drop_model();
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 8'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL reset_idle dut%0d obs=%b exp=%b", i, get_obs(i), exp_o[i]);
                else n_pass++;
            end
        end
        tick(1'b1, 8'($urandom));
        hold = $urandom_range(1, 5);
        for (int c = 0; c < hold; c++) tick(1'b0, 8'($urandom));
        #($urandom_range(1, 3));
        rst = 1'b1;
        drop_model();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (get_obs(i) !== 4'b0000) $display("FAIL reset_async dut%0d obs=%b exp=0000", i, get_obs(i));
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick(1'b0, 8'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL reset_abort dut%0d obs=%b exp=%b", i, get_obs(i), exp_o[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_msb_frame();
        logic [7:0] seq = '0;
        int nbits = 0;
        tick(1'b1, 8'b0110_1100);
        for (int c = 0; c < 11; c++) begin
            if (ifa.dvalid) begin seq = {seq[6:0], ifa.dout}; nbits++; end
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL msb_frame dut%0d cyc=%0d obs=%b exp=%b", i, c, get_obs(i), exp_o[i]);
                else n_pass++;
            end
            if (c < 10) tick(1'b0, 8'($urandom));
        end
        n_total++;
        if (seq !== 8'b0110_1100 || nbits != 8) $display("FAIL msb_bits seq=%b n=%0d exp=01101100 n=8", seq, nbits);
        else n_pass++;
    endtask

    task automatic test_lsb_parity();
        logic [7:0] pdata [3] = '{8'hA5, 8'h07, 8'h03};
        logic       plast [3] = '{1'b0, 1'b1, 1'b0};
        for (int f = 0; f < 3; f++) begin
            logic [7:0] seq = '0;
            int   nc = 0;
            logic lastc = 1'b0;
            tick(1'b1, pdata[f]);
            for (int c = 0; c < 11; c++) begin
                if (ifb.dvalid) seq = {seq[6:0], ifb.dout};
                if (ifc.dvalid) begin nc++; lastc = ifc.dout; end
                for (int i = 0; i < 3; i++) begin
                    n_total++;
                    if (get_obs(i) !== exp_o[i]) $display("FAIL lsb_parity dut%0d f=%0d cyc=%0d obs=%b exp=%b", i, f, c, get_obs(i), exp_o[i]);
                    else n_pass++;
                end
                if (c < 10) tick(1'b0, 8'($urandom));
            end
            if (f == 0) begin
                n_total++;
                if (seq !== 8'b1010_0101) $display("FAIL lsb_bits seq=%b exp=10100101", seq);
                else n_pass++;
            end
            n_total++;
            if (nc != 9 || lastc !== plast[f]) $display("FAIL parity_bit f=%0d n=%0d bit=%b exp n=9 bit=%b", f, nc, lastc, plast[f]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        tick(1'b1, 8'hFF);
        for (int c = 0; c < 31; c++) begin
            if (ifa.done) ndone++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL back_to_back dut%0d cyc=%0d obs=%b exp=%b", i, c, get_obs(i), exp_o[i]);
                else n_pass++;
            end
            if (c < 30) tick(1'b1, 8'h00);
        end
        n_total++;
        if (ndone != 3) $display("FAIL b2b_done_count got=%0d exp=3", ndone);
        else n_pass++;
        for (int c = 0; c < 12; c++) tick(1'b0, 8'h00);
    endtask

    task automatic test_data_churn();
        tick(1'b1, 8'($urandom));
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL data_churn dut%0d cyc=%0d obs=%b exp=%b", i, c, get_obs(i), exp_o[i]);
                else n_pass++;
            end
            tick(1'b0, 8'($urandom));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL random dut%0d edge=%0d obs=%b exp=%b", i, edge_n, get_obs(i), exp_o[i]);
                else n_pass++;
            end
        end
        for (int c = 0; c < 12; c++) tick(1'b0, 8'h00);
    endtask

    task automatic test_loopback();
        logic [7:0] hits = '0;
        logic prev = 1'b0;
        int   pos = 0;
        int   ndone = 0;
        tick(1'b1, 8'b1110_0011);
        for (int c = 0; c < 11; c++) begin
            if (ifa.dvalid) begin
                pos++;
                if (prev && ifa.dout) hits[pos-1] = 1'b1;
                prev = ifa.dout;
            end else prev = 1'b0;
            tick(1'b0, 8'h00);
        end
        n_total++;
        if (hits !== 8'b1000_0110) $display("FAIL loopback_hits got=%b exp=10000110", hits);
        else n_pass++;
        tick(1'b1, 8'b1110_0011);
        for (int c = 0; c < 3; c++) tick(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        drop_model();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 8'h00);
            if (ifa.done) ndone++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (get_obs(i) !== exp_o[i]) $display("FAIL loopback_abort dut%0d cyc=%0d obs=%b exp=%b", i, c, get_obs(i), exp_o[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (ndone != 0) $display("FAIL loopback_no_done got=%0d exp=0", ndone);
        else n_pass++;
    endtask

    initial begin
        drop_model();
        for (int i = 0; i < 3; i++) acc_k[i] = 0;
        test_reset();
        test_msb_frame();
        test_lsb_parity();
        test_back_to_back();
        test_data_churn();
        test_random();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
